// File: rtl/fetch_buffer_if.sv
// Instruction memory bus between the fetch buffer and instruction memory.
// Master issues requests; slave answers with ack and read data.
interface fetch_buffer_if;
    logic        inst_mem_en;
    logic [31:0] inst_mem_addr;
    logic        inst_mem_ack;
    logic [31:0] inst_mem_rd_dat;

    modport master (
        output inst_mem_en,
        output inst_mem_addr,
        input  inst_mem_ack,
        input  inst_mem_rd_dat
    );

    modport slave (
        input  inst_mem_en,
        input  inst_mem_addr,
        output inst_mem_ack,
        output inst_mem_rd_dat
    );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch stage with a one-entry skid buffer and stale-request drop handling.
// Drives the IF/ID pipeline register (pc_id, inst_id, valid_id).
module fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall_if,
    input  logic          stall_id,
    input  logic          flush_id,
    input  logic          new_pc_en,
    input  logic [31:0]   new_pc,
    fetch_buffer_if.master mem,
    output logic [31:0]   pc_if,
    output logic [31:0]   pc_id,
    output logic [31:0]   inst_id,
    output logic          valid_id
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL,
        DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] drop_q, drop_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] inst_id_q, inst_id_d;
    logic        valid_id_q, valid_id_d;

    logic        accept;
    logic        dlv;
    logic [31:0] dlv_inst;
    logic [31:0] pc_inc;

    assign accept = !stall_if && !stall_id;
    assign pc_inc = pc_q + 32'd4;

    // Fetch FSM next state: request, buffer on stall, drop stale responses.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        drop_d   = drop_q;
        dlv      = 1'b0;
        dlv_inst = buf_q;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (mem.inst_mem_ack) begin
                    if (new_pc_en) begin
                        pc_d = new_pc;
                    end else if (accept) begin
                        dlv      = 1'b1;
                        dlv_inst = mem.inst_mem_rd_dat;
                        pc_d     = pc_inc;
                    end else begin
                        buf_d   = mem.inst_mem_rd_dat;
                        state_d = FULL;
                    end
                end else if (new_pc_en) begin
                    drop_d  = pc_q;
                    pc_d    = new_pc;
                    state_d = DROP;
                end
            end
            FULL: begin
                if (new_pc_en) begin
                    pc_d    = new_pc;
                    state_d = REQ;
                end else if (accept) begin
                    dlv      = 1'b1;
                    dlv_inst = buf_q;
                    pc_d     = pc_inc;
                    state_d  = REQ;
                end
            end
            DROP: begin
                if (new_pc_en) begin
                    pc_d = new_pc;
                end
                if (mem.inst_mem_ack) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ID register next state: flush beats stall beats delivery.
    always_comb begin
        pc_id_d    = pc_id_q;
        inst_id_d  = inst_id_q;
        valid_id_d = valid_id_q;
        if (flush_id) begin
            valid_id_d = 1'b0;
            inst_id_d  = NOP;
        end else if (stall_id) begin
            valid_id_d = valid_id_q;
        end else if (dlv) begin
            pc_id_d    = pc_q;
            inst_id_d  = dlv_inst;
            valid_id_d = 1'b1;
        end else begin
            valid_id_d = 1'b0;
            inst_id_d  = NOP;
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            buf_q      <= 32'h0;
            drop_q     <= 32'h0;
            pc_id_q    <= RESET_PC;
            inst_id_q  <= NOP;
            valid_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            drop_q     <= drop_d;
            pc_id_q    <= pc_id_d;
            inst_id_q  <= inst_id_d;
            valid_id_q <= valid_id_d;
        end
    end

    // A request is outstanding in REQ and DROP; reset silences the bus.
    always_comb begin
        mem.inst_mem_en   = !reset && ((state_q == REQ) || (state_q == DROP));
        mem.inst_mem_addr = (state_q == DROP) ? drop_q : pc_q;
    end

    assign pc_if    = pc_q;
    assign pc_id    = pc_id_q;
    assign inst_id  = inst_id_q;
    assign valid_id = valid_id_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed testbench for fetch_buffer.
// Memory data is address ^ 32'hA5A5A5A5; ack is driven per step.
module tb_fetch_buffer;

    localparam logic [31:0] NOPI = 32'h0000_0013;
    localparam logic [31:0] K    = 32'hA5A5_A5A5;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic        new_pc_en;
    logic [31:0] new_pc;
    logic        ack;
    logic [31:0] pc_if;
    logic [31:0] pc_id;
    logic [31:0] inst_id;
    logic        valid_id;

    int tests = 0;
    int fails = 0;

    fetch_buffer_if bus();

    assign bus.inst_mem_ack    = ack;
    assign bus.inst_mem_rd_dat = bus.inst_mem_addr ^ K;

    fetch_buffer #(
        .RESET_PC (32'h0000_0000),
        .NOP      (NOPI)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .stall_if  (stall_if),
        .stall_id  (stall_id),
        .flush_id  (flush_id),
        .new_pc_en (new_pc_en),
        .new_pc    (new_pc),
        .mem       (bus.master),
        .pc_if     (pc_if),
        .pc_id     (pc_id),
        .inst_id   (inst_id),
        .valid_id  (valid_id)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        new_pc_en = 1'b0;
        new_pc    = 32'h0;
        ack       = 1'b1;
        #1;
        step();
        step();
        chk("rst_valid", {31'b0, valid_id}, 32'd0);
        chk("rst_inst", inst_id, NOPI);
        chk("rst_pc_id", pc_id, 32'h0);
        chk("rst_pc_if", pc_if, 32'h0);
        chk("rst_en", {31'b0, bus.inst_mem_en}, 32'd0);

        // streaming, ack every cycle
        reset = 1'b0;
        step();
        chk("s_en", {31'b0, bus.inst_mem_en}, 32'd1);
        chk("s_addr0", bus.inst_mem_addr, 32'h0);
        chk("s_valid0", {31'b0, valid_id}, 32'd0);
        step();
        chk("s_pc0", pc_id, 32'h0);
        chk("s_inst0", inst_id, 32'h0 ^ K);
        chk("s_valid1", {31'b0, valid_id}, 32'd1);
        chk("s_pcif4", pc_if, 32'h4);
        step();
        chk("s_pc4", pc_id, 32'h4);
        chk("s_en_b2b", {31'b0, bus.inst_mem_en}, 32'd1);
        step();
        chk("s_pc8", pc_id, 32'h8);
        chk("s_inst8", inst_id, 32'h8 ^ K);
        step();
        chk("s_pcC", pc_id, 32'hC);
        chk("s_pcif10", pc_if, 32'h10);

        // stall while ack for 0x10 arrives
        stall_if = 1'b1;
        stall_id = 1'b1;
        step();
        chk("f_en0", {31'b0, bus.inst_mem_en}, 32'd0);
        chk("f_hold_pc", pc_id, 32'hC);
        chk("f_pcif", pc_if, 32'h10);
        step();
        step();
        chk("f_hold_pc3", pc_id, 32'hC);
        chk("f_hold_v3", {31'b0, valid_id}, 32'd1);
        chk("f_en3", {31'b0, bus.inst_mem_en}, 32'd0);
        stall_if = 1'b0;
        stall_id = 1'b0;
        step();
        chk("f_rel_pc", pc_id, 32'h10);
        chk("f_rel_inst", inst_id, 32'h10 ^ K);
        chk("f_rel_pcif", pc_if, 32'h14);
        chk("f_rel_addr", bus.inst_mem_addr, 32'h14);
        step();
        chk("f_next", pc_id, 32'h14);
        step();
        step();
        chk("f_pc1C", pc_id, 32'h1C);

        // redirect while request for 0x20 is outstanding
        ack       = 1'b0;
        new_pc_en = 1'b1;
        new_pc    = 32'h200;
        step();
        new_pc_en = 1'b0;
        chk("d_en", {31'b0, bus.inst_mem_en}, 32'd1);
        chk("d_addr", bus.inst_mem_addr, 32'h20);
        chk("d_pcif", pc_if, 32'h200);
        chk("d_valid", {31'b0, valid_id}, 32'd0);
        step();
        chk("d_addr2", bus.inst_mem_addr, 32'h20);
        ack = 1'b1;
        step();
        chk("d_valid2", {31'b0, valid_id}, 32'd0);
        chk("d_inst2", inst_id, NOPI);
        chk("d_addr3", bus.inst_mem_addr, 32'h200);
        step();
        chk("d_pc200", pc_id, 32'h200);
        chk("d_inst200", inst_id, 32'h200 ^ K);

        // ack and redirect in the same cycle
        new_pc_en = 1'b1;
        new_pc    = 32'h80;
        step();
        new_pc_en = 1'b0;
        chk("r_valid", {31'b0, valid_id}, 32'd0);
        chk("r_addr", bus.inst_mem_addr, 32'h80);
        step();
        chk("r_pc80", pc_id, 32'h80);
        chk("r_v80", {31'b0, valid_id}, 32'd1);

        // flush together with stall
        flush_id = 1'b1;
        stall_id = 1'b1;
        step();
        flush_id = 1'b0;
        stall_id = 1'b0;
        chk("fl_valid", {31'b0, valid_id}, 32'd0);
        chk("fl_inst", inst_id, NOPI);
        chk("fl_pc_id", pc_id, 32'h80);
        chk("fl_pcif", pc_if, 32'h84);
        step();
        chk("fl_pc84", pc_id, 32'h84);
        chk("fl_inst84", inst_id, 32'h84 ^ K);
        chk("fl_pcif88", pc_if, 32'h88);

        // reset while in DROP with ack in the reset cycle
        ack       = 1'b0;
        new_pc_en = 1'b1;
        new_pc    = 32'h300;
        step();
        new_pc_en = 1'b0;
        chk("rd_addr", bus.inst_mem_addr, 32'h88);
        chk("rd_pcif", pc_if, 32'h300);
        reset = 1'b1;
        ack   = 1'b1;
        #1;
        chk("rd_en_rst", {31'b0, bus.inst_mem_en}, 32'd0);
        step();
        chk("rd_pcif0", pc_if, 32'h0);
        chk("rd_en", {31'b0, bus.inst_mem_en}, 32'd0);
        chk("rd_valid", {31'b0, valid_id}, 32'd0);
        reset = 1'b0;
        step();
        chk("rd_req", bus.inst_mem_addr, 32'h0);

        // PC wrap
        new_pc_en = 1'b1;
        new_pc    = 32'hFFFF_FFFC;
        step();
        new_pc_en = 1'b0;
        chk("w_pcif", pc_if, 32'hFFFF_FFFC);
        step();
        chk("w_pc_id", pc_id, 32'hFFFF_FFFC);
        chk("w_wrap", pc_if, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
